// File: rtl/srm_ctrl.sv
// rtl/srm_ctrl.sv - instruction-sequencing controller for a simple register machine
module srm_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        done,
  output logic        err,
  output logic        halted,
  output logic [3:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WRREG, S_WRIMM, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic        err_q;
  logic        ready_en;
  logic        accept;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  // Decoded instruction classes; anything not matched here is illegal.
  logic is_movi, is_mov, is_alu, is_cmp, is_mvn, is_halt, legal;
  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov  = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign is_halt = (opcode == 3'b111);
  assign legal   = is_movi | is_mov | is_alu | is_halt;

  assign accept = instr_valid & instr_ready;

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // State register; reset returns to WAIT immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;
  end

  // Instruction register loads only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ir <= 16'h0000;
    else if (accept) ir <= instr;
  end

  // Sticky illegal-opcode flag, cleared by the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_q <= 1'b0;
    else if (accept)                           err_q <= 1'b0;
    else if ((state == S_DECODE) && !legal)    err_q <= 1'b1;
  end

  // Keeps instr_ready low while reset is held; ready from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Next-state and Moore control outputs from state and IR.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = err_q;
    halted      = 1'b0;
    vsel        = 4'b0000;
    asel        = 1'b0;
    bsel        = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    write       = 1'b0;
    ALUop       = 2'b00;
    shift       = 2'b00;
    readnum     = 3'b000;
    writenum    = 3'b000;
    case (state)
      S_WAIT: begin
        instr_ready = ready_en;
        if (accept) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)                 state_nxt = S_WRIMM;
        else if (is_mov || is_mvn)   state_nxt = S_GETB;
        else if (is_alu)             state_nxt = S_GETA;
        else if (is_halt)            state_nxt = S_HALT;
        else begin
          state_nxt = S_WAIT;
          err       = 1'b1;
          done      = 1'b1;
        end
      end
      S_GETA: begin
        readnum   = rn;
        loada     = 1'b1;
        state_nxt = S_GETB;
      end
      S_GETB: begin
        readnum   = rm;
        loadb     = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        ALUop = is_mov ? 2'b00 : op;
        asel  = is_mov | is_mvn;
        loadc = !is_cmp;
        loads = is_cmp;
        if (is_cmp) begin
          done      = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_WRREG;
        end
      end
      S_WRREG: begin
        vsel      = 4'b1000;
        writenum  = rd;
        write     = 1'b1;
        done      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WRIMM: begin
        vsel      = 4'b0010;
        writenum  = rn;
        write     = 1'b1;
        done      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

endmodule
